// File: rtl/picture_loader.sv
// rtl/picture_loader.sv - packs UART bytes into pixels and writes them to picture BRAM side A
// Optional trailing XOR checksum byte: define PICTURE_LOADER_CHECKSUM_EN.
module picture_loader #(
    parameter int NUM_CH  = 3,
    parameter int CH_BITS = 6,
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int ADDR_W  = 19,
    parameter int TIMEOUT = 100000
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [7:0]                  rx_data,
    input  logic                        rx_valid,
    input  logic                        restart,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [NUM_CH*CH_BITS-1:0]   wr_data,
    output logic [1:0]                  done
);

    localparam int PIXELS = H_RES * V_RES;
    localparam int PIX_W  = NUM_CH * CH_BITS;
    localparam int BC_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(PIXELS - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] DONE_IDLE     = 2'b00;
    localparam logic [1:0] DONE_LOADING  = 2'b01;
    localparam logic [1:0] DONE_COMPLETE = 2'b10;
    localparam logic [1:0] DONE_ERROR    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef PICTURE_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q;
    logic [1:0]          done_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [PIX_W-1:0]    wr_data_q;
    logic [BC_W-1:0]     byte_cnt_q;
    logic [ADDR_W-1:0]   pix_q;
    logic [IDLE_W-1:0]   idle_q;
    logic [PIX_W-1:0]    accum_q;
`ifdef PICTURE_LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic [CH_BITS-1:0]  chan_d;
    logic [PIX_W-1:0]    pixel_d;
    logic                timeout_hit_d;
    logic                unused_rx_bits;

    // Low bits of each byte are discarded by the packing; only the checksum reads them.
    assign unused_rx_bits = ^rx_data;
    assign chan_d         = rx_data[7 -: CH_BITS];
    assign timeout_hit_d  = (TIMEOUT != 0) && (idle_q == IDLE_MAX);

    always_comb begin
        pixel_d = accum_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (byte_cnt_q == BC_W'(k)) begin
                pixel_d[(NUM_CH-1-k)*CH_BITS +: CH_BITS] = chan_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            done_q     <= DONE_IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            byte_cnt_q <= '0;
            pix_q      <= '0;
            idle_q     <= '0;
            accum_q    <= '0;
`ifdef PICTURE_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            if (restart) begin
                state_q    <= S_IDLE;
                done_q     <= DONE_IDLE;
                byte_cnt_q <= '0;
                pix_q      <= '0;
                idle_q     <= '0;
                accum_q    <= '0;
`ifdef PICTURE_LOADER_CHECKSUM_EN
                csum_q     <= '0;
`endif
            end else begin
                case (state_q)
                    // IDLE counters are already clear, so its first byte is byte 0 of pixel 0.
                    S_IDLE, S_LOAD: begin
                        if (rx_valid) begin
                            idle_q  <= '0;
                            state_q <= S_LOAD;
                            done_q  <= DONE_LOADING;
`ifdef PICTURE_LOADER_CHECKSUM_EN
                            csum_q  <= csum_q ^ rx_data;
`endif
                            if (byte_cnt_q == LAST_BYTE) begin
                                wr_en_q    <= 1'b1;
                                wr_addr_q  <= pix_q;
                                wr_data_q  <= pixel_d;
                                byte_cnt_q <= '0;
                                if (pix_q == LAST_PIX) begin
`ifdef PICTURE_LOADER_CHECKSUM_EN
                                    state_q <= S_CHK;
`else
                                    state_q <= S_DONE;
                                    done_q  <= DONE_COMPLETE;
`endif
                                end else begin
                                    pix_q <= pix_q + 1'b1;
                                end
                            end else begin
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                                accum_q    <= pixel_d;
                            end
                        end else if (state_q == S_LOAD) begin
                            if (timeout_hit_d) begin
                                state_q    <= S_ERR;
                                done_q     <= DONE_ERROR;
                                byte_cnt_q <= '0;
                                accum_q    <= '0;
                            end else if (TIMEOUT != 0) begin
                                idle_q <= idle_q + 1'b1;
                            end
                        end
                    end
`ifdef PICTURE_LOADER_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_valid) begin
                            idle_q <= '0;
                            if (rx_data == csum_q) begin
                                state_q <= S_DONE;
                                done_q  <= DONE_COMPLETE;
                            end else begin
                                state_q <= S_ERR;
                                done_q  <= DONE_ERROR;
                            end
                        end else if (timeout_hit_d) begin
                            state_q <= S_ERR;
                            done_q  <= DONE_ERROR;
                        end else if (TIMEOUT != 0) begin
                            idle_q <= idle_q + 1'b1;
                        end
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_picture_loader.sv
// tb/tb_picture_loader.sv - self-checking bench for picture_loader (RGB and greyscale builds)
module tb_picture_loader;

`ifdef PICTURE_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  done;
        logic        en;
        logic        chk;
        logic [7:0]  x;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] k;
        logic [31:0] pix;
        logic [31:0] idle;
        logic [31:0] acc;
    } m_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v [2];
    logic [7:0] d [2];
    logic       rs [2];

    logic        a_en, g_en;
    logic [1:0]  a_addr, g_addr;
    logic [17:0] a_wd;
    logic [7:0]  g_wd;
    logic [1:0]  a_done, g_done;

    int checks = 0;
    int failures = 0;
    m_t m0 = '0;
    m_t m1 = '0;

    always #5 clk = ~clk;

    picture_loader #(.NUM_CH(3), .CH_BITS(6), .H_RES(2), .V_RES(2), .ADDR_W(2), .TIMEOUT(10)) u_rgb (
        .clk(clk), .reset_n(rst_n), .rx_data(d[0]), .rx_valid(v[0]), .restart(rs[0]),
        .wr_en(a_en), .wr_addr(a_addr), .wr_data(a_wd), .done(a_done));

    picture_loader #(.NUM_CH(1), .CH_BITS(8), .H_RES(4), .V_RES(1), .ADDR_W(2), .TIMEOUT(0)) u_grey (
        .clk(clk), .reset_n(rst_n), .rx_data(d[1]), .rx_valid(v[1]), .restart(rs[1]),
        .wr_en(g_en), .wr_addr(g_addr), .wr_data(g_wd), .done(g_done));

    // Frame-level model: byte counts, packing arithmetic and idle counting straight from the rules.
    function automatic m_t step(input m_t s, input int nch, input int bits, input int pixels,
                                input int tmo, input logic rn, input logic vv,
                                input logic [7:0] dd, input logic rr);
        m_t n;
        n = s;
        n.en = 1'b0;
        if (!rn) return '0;
        if (rr) begin
            n = '0;
            n.addr = s.addr;
            n.data = s.data;
            return n;
        end
        if (s.done == 2'b10 || s.done == 2'b11) return n;
        if (vv) begin
            n.idle = 0;
            if (s.chk) begin
                n.chk = 1'b0;
                n.done = (dd == s.x) ? 2'b10 : 2'b11;
            end else begin
                n.done = 2'b01;
                n.x = s.x ^ dd;
                n.acc = s.acc | ((32'(dd) >> (8 - bits)) << ((nch - 1 - int'(s.k)) * bits));
                n.k = s.k + 1;
                if (int'(n.k) == nch) begin
                    n.en = 1'b1;
                    n.addr = s.pix;
                    n.data = n.acc;
                    n.acc = 0;
                    n.k = 0;
                    n.pix = s.pix + 1;
                    if (int'(n.pix) == pixels) begin
                        if (CK) n.chk = 1'b1;
                        else n.done = 2'b10;
                    end
                end
            end
        end else if (s.done == 2'b01) begin
            n.idle = s.idle + 1;
            if (tmo != 0 && int'(n.idle) == tmo) begin
                n.done = 2'b11;
                n.k = 0;
                n.acc = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        m0 = step(m0, 3, 6, 4, 10, rst_n, v[0], d[0], rs[0]);
        m1 = step(m1, 1, 8, 4, 0, rst_n, v[1], d[1], rs[1]);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("rgb_done", 32'(a_done), 32'(m0.done));
        check("rgb_wr_en", 32'(a_en), 32'(m0.en));
        check("rgb_wr_addr", 32'(a_addr), m0.addr);
        check("rgb_wr_data", 32'(a_wd), m0.data);
        check("grey_done", 32'(g_done), 32'(m1.done));
        check("grey_wr_en", 32'(g_en), 32'(m1.en));
        check("grey_wr_addr", 32'(g_addr), m1.addr);
        check("grey_wr_data", 32'(g_wd), m1.data);
    end

    task automatic put(input int i, input logic vv, input logic [7:0] dd);
        v[i] = vv;
        d[i] = dd;
        @(negedge clk);
        v[i] = 1'b0;
    endtask

    task automatic do_restart(input int i);
        rs[i] = 1'b1;
        put(i, 1'b0, 8'h00);
        rs[i] = 1'b0;
    endtask

    logic [7:0] frame [12];
    logic [7:0] gb [4];
    logic [7:0] fx;

    initial begin
        frame = '{8'hFC, 8'h80, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
        gb = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0;
            d[i] = 8'h00;
            rs[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset_done", 32'(a_done), 32'h0);
        check("reset_wr_en", 32'(a_en), 32'h0);
        check("reset_wr_addr", 32'(a_addr), 32'h0);
        check("reset_wr_data", 32'(a_wd), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // RGB packing, first pixel on back-to-back strobes
        for (int i = 0; i < 3; i++) put(0, 1'b1, frame[i]);
        check("rgb_px0_en", 32'(a_en), 32'h1);
        check("rgb_px0_addr", 32'(a_addr), 32'h0);
        check("rgb_px0_data", 32'(a_wd), 32'h3F801);
        check("rgb_loading", 32'(a_done), 32'h1);
        put(0, 1'b0, 8'h00);
        check("rgb_pulse_one_cycle", 32'(a_en), 32'h0);
        check("rgb_data_hold", 32'(a_wd), 32'h3F801);
        for (int i = 3; i < 12; i++) put(0, 1'b1, frame[i]);
        check("rgb_last_addr", 32'(a_addr), 32'h3);
        check("rgb_last_data", 32'(a_wd), 32'h1C824);
        check("rgb_done_with_last", 32'(a_done), CK ? 32'h1 : 32'h2);
        fx = 8'h00;
        for (int i = 0; i < 12; i++) fx = fx ^ frame[i];
        put(0, 1'b1, CK ? fx : 8'hEE);
        put(0, 1'b0, 8'h00);
        check("rgb_extra_byte_done", 32'(a_done), 32'h2);
        check("rgb_extra_byte_no_write", 32'(a_en), 32'h0);
        do_restart(0);
        check("rgb_restart_from_done", 32'(a_done), 32'h0);

        // Reset mid-load after 4 bytes, then reload from pixel 0
        for (int i = 0; i < 4; i++) put(0, 1'b1, frame[i]);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("midreset_done", 32'(a_done), 32'h0);
        check("midreset_wr_en", 32'(a_en), 32'h0);
        check("midreset_wr_addr", 32'(a_addr), 32'h0);
        check("midreset_wr_data", 32'(a_wd), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        put(0, 1'b1, 8'hAA);
        put(0, 1'b1, 8'hBB);
        put(0, 1'b1, 8'hCC);
        check("reload_en", 32'(a_en), 32'h1);
        check("reload_addr", 32'(a_addr), 32'h0);
        check("reload_data", 32'(a_wd), 32'h2ABB3);

        // Timeout: two bytes then silence
        do_restart(0);
        put(0, 1'b1, 8'hFC);
        put(0, 1'b1, 8'h80);
        for (int i = 0; i < 9; i++) put(0, 1'b0, 8'h00);
        check("timeout_not_early", 32'(a_done), 32'h1);
        put(0, 1'b0, 8'h00);
        check("timeout_exact", 32'(a_done), 32'h3);
        put(0, 1'b1, 8'h12);
        put(0, 1'b1, 8'h34);
        put(0, 1'b1, 8'h56);
        check("error_ignores_bytes", 32'(a_done), 32'h3);
        check("error_no_write", 32'(a_en), 32'h0);
        do_restart(0);
        check("restart_from_error", 32'(a_done), 32'h0);

        // Restart colliding with a strobe mid-load
        put(0, 1'b1, 8'h11);
        rs[0] = 1'b1;
        put(0, 1'b1, 8'h55);
        rs[0] = 1'b0;
        check("collision_done", 32'(a_done), 32'h0);
        put(0, 1'b1, 8'h04);
        put(0, 1'b1, 8'h08);
        put(0, 1'b1, 8'h0C);
        check("collision_addr", 32'(a_addr), 32'h0);
        check("collision_data", 32'(a_wd), 32'h01083);

        // Greyscale back-to-back
        for (int i = 0; i < 4; i++) begin
            put(1, 1'b1, gb[i]);
            check("grey_en", 32'(g_en), 32'h1);
            check("grey_addr", 32'(g_addr), 32'(i));
            check("grey_data", 32'(g_wd), 32'(gb[i]));
        end
        check("grey_done_with_last", 32'(g_done), CK ? 32'h1 : 32'h2);
`ifdef PICTURE_LOADER_CHECKSUM_EN
        put(1, 1'b1, 8'h44);
        check("csum_good", 32'(g_done), 32'h2);
        do_restart(1);
        for (int i = 0; i < 4; i++) put(1, 1'b1, gb[i]);
        put(1, 1'b1, 8'h45);
        check("csum_bad", 32'(g_done), 32'h3);
`else
        put(1, 1'b1, 8'h99);
        check("grey_ignore_after_done", 32'(g_done), 32'h2);
        check("grey_no_write_after_done", 32'(g_en), 32'h0);
`endif
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
